rr_encoder_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 8x3 encoded-index resource among 8 requesters.

---
 rtl/rr_encoder_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared 8x3 encoded-index resource.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 15
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_valid_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic [IDXW-1:0] idx_q;
  logic            valid_q;
  logic [IDXW-1:0] ptr_q;

  logic            found_d;
  logic [IDXW-1:0] sel_d;
  logic [N-1:0]    grant_d;
  logic            owner_req_d;
  logic            exit_d;
  logic            force_d;

  // Rotating search: offset 0 from ptr has the highest priority. The index adder
  // wraps naturally because N == 2**IDXW.
  function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] k;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = p + IDXW'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CNTW-1:0] cnt_q;
  logic            timeout_q;
  assign force_d   = (cnt_q == CNTW'(MAX_HOLD - 1));
  assign timeout_o = timeout_q;
`else
  assign force_d   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    {found_d, sel_d} = pick(req_i, ptr_q);
    grant_d          = N'(1) << sel_d;
    owner_req_d      = req_i[idx_q];
    exit_d           = done_i | ~owner_req_d | force_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= GRANT;
            grant_q <= grant_d;
            idx_q   <= sel_d;
            valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        GRANT: begin
          if (exit_d) begin
            // All exit causes share this single transition, so coincident causes
            // still yield one RELEASE cycle.
            state_q <= RELEASE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + IDXW'(1);
`ifdef ARB_TIMEOUT_EN
            timeout_q <= force_d & ~done_i & owner_req_d;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_q <= cnt_q + CNTW'(1);
`endif
          end
        end
        RELEASE: begin
          state_q <= IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter: reset, rotation, release causes, hold/timeout.
module tb_rr_encoder_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] gidx;
  logic       gvld;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  rr_encoder_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .done_i       (done),
    .grant_o      (grant),
    .grant_idx_o  (gidx),
    .grant_valid_o(gvld),
    .timeout_o    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (grant !== 8'h00) begin failures++; $display("FAIL reset_grant cyc=%0d got=%h exp=00", c, grant); end
      checks++; if (gvld !== 1'b0)   begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, gvld); end
      checks++; if (gidx !== 3'd0)   begin failures++; $display("FAIL reset_idx cyc=%0d got=%0d exp=0", c, gidx); end
      checks++; if (tmo !== 1'b0)    begin failures++; $display("FAIL reset_timeout cyc=%0d got=%b exp=0", c, tmo); end
    end
    rst = 1'b0; req = 8'h00;
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    tick();
    checks++; if (grant !== 8'b0000_0100) begin failures++; $display("FAIL single_grant got=%b exp=00000100", grant); end
    checks++; if (gidx !== 3'd2)          begin failures++; $display("FAIL single_idx got=%0d exp=2", gidx); end
    checks++; if (gvld !== 1'b1)          begin failures++; $display("FAIL single_valid got=%b exp=1", gvld); end
    tick();
    checks++; if (grant !== 8'b0000_0100 || gidx !== 3'd2) begin failures++; $display("FAIL single_hold got=%b/%0d exp=00000100/2", grant, gidx); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (grant !== 8'h00 || gvld !== 1'b0 || gidx !== 3'd0) begin failures++; $display("FAIL single_release got=%h/%b/%0d exp=00/0/0", grant, gvld, gidx); end
    req = 8'hFF;
    tick();
    checks++; if (gvld !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", gvld); end
    tick();
    checks++; if (grant !== 8'b0000_1000 || gidx !== 3'd3) begin failures++; $display("FAIL single_ptr3 got=%b/%0d exp=00001000/3", grant, gidx); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      e = 3'(g % 8);
      checks++; if (gidx !== e || grant !== (8'd1 << e) || gvld !== 1'b1) begin
        failures++; $display("FAIL b2b_grant n=%0d got=%b/%0d exp_idx=%0d", g, grant, gidx, e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (gvld !== 1'b0 || grant !== 8'h00) begin failures++; $display("FAIL b2b_release n=%0d got=%h/%b exp=00/0", g, grant, gvld); end
      tick();
      checks++; if (gvld !== 1'b0) begin failures++; $display("FAIL b2b_idle n=%0d got=%b exp=0", g, gvld); end
      tick();
    end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_drop_and_done();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'b0010_0000;
    tick();
    checks++; if (gidx !== 3'd5 || grant !== 8'b0010_0000) begin failures++; $display("FAIL drop_first got=%b/%0d exp=00100000/5", grant, gidx); end
    req = 8'b0000_0001; done = 1'b1;
    tick();
    done = 1'b0; req = 8'b0010_0001;
    checks++; if (gvld !== 1'b0 || grant !== 8'h00) begin failures++; $display("FAIL drop_release got=%h/%b exp=00/0", grant, gvld); end
    tick();
    checks++; if (gvld !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", gvld); end
    tick();
    checks++; if (gidx !== 3'd0 || grant !== 8'b0000_0001 || gvld !== 1'b1) begin failures++; $display("FAIL drop_next got=%b/%0d exp=00000001/0", grant, gidx); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'b0001_0000;
    tick();
    checks++; if (gidx !== 3'd4 || gvld !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%0d/%b exp=4/1", gidx, gvld); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 8'b0001_0001;
    checks++; if (grant !== 8'h00 || gvld !== 1'b0 || gidx !== 3'd0 || tmo !== 1'b0) begin
      failures++; $display("FAIL midrst_clear got=%h/%b/%0d/%b exp=00/0/0/0", grant, gvld, gidx, tmo);
    end
    tick();
    checks++; if (gidx !== 3'd0 || grant !== 8'b0000_0001 || gvld !== 1'b1) begin failures++; $display("FAIL midrst_ptr got=%b/%0d exp=00000001/0", grant, gidx); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_hold();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'b1000_0000;
    tick();
    checks++; if (gidx !== 3'd7 || grant !== 8'b1000_0000) begin failures++; $display("FAIL hold_first got=%b/%0d exp=10000000/7", grant, gidx); end
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++; if (grant !== 8'b1000_0000 || tmo !== 1'b0) begin failures++; $display("FAIL hold_held cyc=%0d got=%b/%b exp=10000000/0", c, grant, tmo); end
    end
    tick();
    checks++; if (grant !== 8'h00 || tmo !== 1'b1) begin failures++; $display("FAIL hold_timeout got=%h/%b exp=00/1", grant, tmo); end
    tick();
    checks++; if (grant !== 8'h00 || tmo !== 1'b0) begin failures++; $display("FAIL hold_pulse_end got=%h/%b exp=00/0", grant, tmo); end
    tick();
    checks++; if (gidx !== 3'd7 || grant !== 8'b1000_0000 || gvld !== 1'b1) begin failures++; $display("FAIL hold_regrant got=%b/%0d exp=10000000/7", grant, gidx); end
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++; if (grant !== 8'b1000_0000 || gvld !== 1'b1 || tmo !== 1'b0) begin
        failures++; $display("FAIL hold_held cyc=%0d got=%b/%b/%b exp=10000000/1/0", c, grant, gvld, tmo);
      end
    end
`endif
    req = 8'h00;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop_and_done();
    test_reset_mid_grant();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
